control_unit_fsm: RTL and testbench
===================================

Name: control_unit_fsm

Overview:
- Moore-style sequencing controller for the multicycle 8-bit add/subtract datapath.
- On a start request it steps the datapath through four phases: load operand A into the accumulator register, then accumulate B, C and D.
- It then raises done.
- Drives register enable (e), A-load mux select (s0) and the 3:1 operand-mux selects (s1, s2).

Parameters:
- none (fixed 4-operand sequence; state encoding is internal).

Ports:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; forces IDLE.
- start  input  1  operation request, level-sampled on the rising clock edge.
- mode  input  1  add(0)/subtract(1) selection, routed to the datapath in parallel; not used for sequencing.
- e  output  1  accumulator register load enable.
- s0  output  1  1 = register input takes operand A; 0 = takes adder output.
- s1  output  1  operand mux select low: 1 selects C.
- s2  output  1  operand mux select high: 1 selects D; s1=s2=0 selects B.
- done  output  1  result valid / operation complete.
- Positional port order for instantiation: start, mode, clock, reset, e, s0, s1, s2, done.

Behaviour:
- States: IDLE, LOAD_A, ACC_B, ACC_C, ACC_D, DONE.
- One state register, updated only on the rising edge of clock. Outputs decode from state only: no combinational path from start or mode to any output.
- Output table (e, s0, s1, s2, done):
  - IDLE = 0,0,0,0,0
  - LOAD_A = 1,1,0,0,0
  - ACC_B = 1,0,0,0,0
  - ACC_C = 1,0,1,0,0
  - ACC_D = 1,0,0,1,0
  - DONE = 0,0,0,0,1
- s1 and s2 are never both 1.
- Transitions:
  - IDLE→LOAD_A when start=1, else stay.
  - LOAD_A→ACC_B→ACC_C→ACC_D→DONE unconditionally, one cycle each.
  - DONE→IDLE when start=0; stays in DONE while start=1, so one start level yields exactly one operation.
- Latency: start sampled high at edge N → LOAD_A after N. The B, C and D phases follow after N+1, N+2 and N+3. done=1 after edge N+4 and holds until start is low at an edge.
- e is high for exactly 4 consecutive cycles per operation.
- start toggling while in LOAD_A…ACC_D is ignored; the sequence completes.
- Reset:
  - reset=1 at any edge → IDLE, all outputs 0 after that edge, including mid-operation and in DONE.
  - reset has priority over start.
  - Before the first reset edge, state is undefined. Benches must apply reset first.
- start=1 and reset=1 on the same edge: result is IDLE. start is re-evaluated on the next edge.
- mode changes during an operation do not alter the state sequence.
- Illegal or unused state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD_A, ACC_B, ACC_C, ACC_D, DONE);
  - named select constants SEL_B={s2,s1}=00, SEL_C=01, SEL_D=10;
  - S0_LOAD_A=1.
- No sub-module needed. An optional output-decode function lives inside the block.

Test Plan:
- Reset, then start=0 for 3 cycles → stays IDLE; e=s0=s1=s2=done=0 each cycle.
- start=1 for one cycle, then 0 → outputs on the next 5 cycles:
  - (e,s0,s1,s2,done) = 11000, 10000, 10100, 10010, 00001;
  - then IDLE all-zero.
- start held at 1 throughout → done stays 1 after the sequence. Dropping start gives IDLE next cycle. Re-raising start gives a new LOAD_A.
- reset=1 asserted while in ACC_C → next cycle all outputs 0 (IDLE); with start=1, LOAD_A follows one cycle after reset drops.
- start pulsed again during ACC_B, and mode toggled mid-sequence → sequence unchanged and completes in DONE on schedule.
- Check every cycle: s1&s2 never both 1; e=1 count per operation = 4; done and e never both 1.

Source files
------------

// File: rtl/control_unit_fsm_pkg.sv
// Shared constants for the multicycle add/subtract sequencing controller.
// State codes stay plain localparams so legacy code can compare them against raw 3-bit values.
package control_unit_fsm_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] ACC_B  = 3'd2;
  localparam logic [2:0] ACC_C  = 3'd3;
  localparam logic [2:0] ACC_D  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  // Operand mux selects, packed as {s2, s1}.
  localparam logic [1:0] SEL_B = 2'b00;
  localparam logic [1:0] SEL_C = 2'b01;
  localparam logic [1:0] SEL_D = 2'b10;

  localparam logic S0_LOAD_A = 1'b1;

  typedef struct packed {
    logic       e;
    logic       s0;
    logic [1:0] sel;
    logic       done;
  } ctrlOutT;

endpackage

// File: rtl/control_unit_fsm.sv
// Moore controller: loads A, then accumulates B, C and D, then holds done until start drops.
// Outputs decode from the state register only.
module control_unit_fsm
  import control_unit_fsm_pkg::*;
(
  input  logic start,
  input  logic mode,
  input  logic clock,
  input  logic reset,
  output logic e,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic done
);

  logic [2:0] state;
  logic [2:0] nextState;
  ctrlOutT    outs;

  // mode goes straight to the datapath; the sequencer ignores it.
  logic unusedMode;
  assign unusedMode = mode;

  function automatic ctrlOutT decodeOutputs(input logic [2:0] st);
    ctrlOutT o;
    o = '{e: 1'b0, s0: 1'b0, sel: SEL_B, done: 1'b0};
    case (st)
      LOAD_A: begin
        o.e  = 1'b1;
        o.s0 = S0_LOAD_A;
      end
      ACC_B: begin
        o.e   = 1'b1;
        o.sel = SEL_B;
      end
      ACC_C: begin
        o.e   = 1'b1;
        o.sel = SEL_C;
      end
      ACC_D: begin
        o.e   = 1'b1;
        o.sel = SEL_D;
      end
      DONE:    o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:    nextState = start ? LOAD_A : IDLE;
      LOAD_A:  nextState = ACC_B;
      ACC_B:   nextState = ACC_C;
      ACC_C:   nextState = ACC_D;
      ACC_D:   nextState = DONE;
      // Holding here while start stays high makes one start level yield one operation.
      DONE:    nextState = start ? DONE : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    outs = decodeOutputs(state);
    e    = outs.e;
    s0   = outs.s0;
    s1   = outs.sel[0];
    s2   = outs.sel[1];
    done = outs.done;
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: directed scenarios then random start/mode/reset,
// compared every cycle against a cycle-count model of the operation.
module tb_control_unit_fsm;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic mode  = 1'b0;
  logic e, s0, s1, s2, done;

  int checks = 0;
  int errors = 0;

  // Model: phase = cycles into the current operation (0 idle, 1..4 register loads, 5 done).
  int phase = 0;
  int eRun = 0;
  logic prevDone = 1'b0;

  control_unit_fsm dut (
    .start(start),
    .mode (mode),
    .clock(clock),
    .reset(reset),
    .e    (e),
    .s0   (s0),
    .s1   (s1),
    .s2   (s2),
    .done (done)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] expectedOutputs(input int p);
    logic [4:0] v;
    v[4] = (p >= 1 && p <= 4);
    v[3] = (p == 1);
    v[2] = (p == 3);
    v[1] = (p == 4);
    v[0] = (p == 5);
    return v;
  endfunction

  task automatic step(input logic st, input logic md, input logic rs, input string tag);
    logic [4:0] observed;
    logic [4:0] expected;
    start = st;
    mode  = md;
    reset = rs;
    @(posedge clock);
    if (rs) phase = 0;
    else if (phase == 0) phase = st ? 1 : 0;
    else if (phase < 5) phase = phase + 1;
    else phase = st ? 5 : 0;
    #1;
    observed = {e, s0, s1, s2, done};
    expected = expectedOutputs(phase);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s outputs(e,s0,s1,s2,done) observed=%b expected=%b", tag, observed,
             expected);
    end
    checks++;
    assert ((s1 & s2) === 1'b0) else begin
      errors++;
      $error("FAIL %s s1s2_exclusive observed=%b%b expected=not 11", tag, s1, s2);
    end
    checks++;
    assert ((e & done) === 1'b0) else begin
      errors++;
      $error("FAIL %s e_done_exclusive observed e=%b done=%b expected not both 1", tag, e, done);
    end
    if (e === 1'b1) begin
      eRun++;
    end else begin
      if (done === 1'b1 && prevDone !== 1'b1) begin
        checks++;
        assert (eRun === 4) else begin
          errors++;
          $error("FAIL %s e_count observed=%0d expected=4", tag, eRun);
        end
      end
      eRun = 0;
    end
    prevDone = done;
    #1;
  endtask

  initial begin
    // Reset first; state is undefined before it.
    step(1'b0, 1'b0, 1'b1, "reset");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "idle_hold");

    // Single-cycle start pulse.
    step(1'b1, 1'b0, 1'b0, "pulse_load_a");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, "pulse_seq");

    // start held high: done holds, drop returns to idle, re-raise starts again.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, "held_start");
    step(1'b0, 1'b1, 1'b0, "held_drop");
    step(1'b1, 1'b0, 1'b0, "held_reraise");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, "reraise_seq");

    // Reset while in ACC_C, with start high; LOAD_A follows once reset drops.
    step(1'b1, 1'b0, 1'b0, "midreset_load_a");
    step(1'b0, 1'b0, 1'b0, "midreset_acc_b");
    step(1'b0, 1'b0, 1'b0, "midreset_acc_c");
    step(1'b1, 1'b0, 1'b1, "midreset_reset");
    step(1'b1, 1'b0, 1'b0, "midreset_restart");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, "midreset_seq");

    // start re-pulsed during ACC_B and mode toggled mid-sequence.
    step(1'b1, 1'b0, 1'b0, "ignore_load_a");
    step(1'b0, 1'b1, 1'b0, "ignore_acc_b");
    step(1'b1, 1'b0, 1'b0, "ignore_acc_c");
    step(1'b0, 1'b1, 1'b0, "ignore_acc_d");
    step(1'b0, 1'b0, 1'b0, "ignore_done");
    step(1'b0, 1'b1, 1'b0, "ignore_idle");

    // Random start/mode with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 24) == 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
